prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream bootloader that writes programs into the single-cycle CPU's 256x16 instruction memory.
- It drives the memory's write data, write address and write-enable inputs.
- Receives framed bytes from a serial front end over a valid/ready handshake, assembles 16-bit words high byte first, and writes them at consecutive addresses.
- Holds the CPU in load mode until the frame checksum passes. Releasing the write enable restarts the CPU at PC 0.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 50000, max idle cycles between bytes inside a frame before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- inst_data  output  16  instruction word to memory write data.
- inst_add  output  8  instruction memory write address.
- instr_wenable  output  1  level; high = memory write enabled and CPU held in load mode.
- word_wr  output  1  one-cycle pulse when inst_data/inst_add update to a new word.
- load_done  output  1  one-cycle pulse on successful frame.
- load_error  output  1  sticky frame error flag.

Behaviour:
- Byte accepted on a rising edge when rx_valid && rx_ready. Nothing is consumed otherwise.
- Frame format: SYNC_BYTE, CNT (word count minus 1, so 1..256 words), 2*(CNT+1) data bytes (hi, lo per word), CHK.
- CHK = XOR of all data bytes. SYNC and CNT are not included.
- Reset values: state IDLE, rx_ready 1, inst_data 0, inst_add 0, instr_wenable 0, word_wr 0, load_done 0, load_error 0. Internal word index 0, checksum 0, timeout counter 0.
- Reset has priority over all events, including mid-frame. instr_wenable drops the next cycle, and the partially loaded memory is left as is.
- States: IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
- IDLE:
  - instr_wenable 0.
  - Byte == SYNC_BYTE -> COUNT. instr_wenable rises the following cycle; load_error clears; index and checksum clear.
  - Any other byte is discarded.
- COUNT: accepted byte latched as CNT -> HI.
- HI: byte latched as high half; checksum ^= byte -> LO.
- LO, on byte acceptance:
  - checksum ^= byte.
  - Next cycle: inst_data = {hi, byte}, inst_add = index, word_wr = 1 for one cycle.
  - If index == CNT -> CHECK; else index += 1 (8-bit, no wrap is possible since CNT max 255) -> HI.
- Between words, inst_data/inst_add hold the last written word. Repeated memory writes of that same word while enabled are harmless.
- CHECK: byte == checksum -> DONE; else -> ERR.
- DONE (one cycle):
  - instr_wenable 0, load_done 1, rx_ready 0 -> IDLE.
  - The falling edge of instr_wenable restarts the CPU.
- ERR:
  - instr_wenable held 1, keeping the CPU out of run mode; load_error 1.
  - rx_ready 1. Bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE restarts the frame (-> COUNT, load_error clears).
- Timeout:
  - In COUNT/HI/LO/CHECK the counter increments each cycle with no accepted byte and clears on acceptance.
  - Reaching TIMEOUT -> ERR.
  - Counter is 16 bits and saturating.
- A SYNC_BYTE value received inside a frame is treated as data, with no resync.
- rx_ready is 0 only in DONE.

Test Plan:
- Nominal 3-word load: bytes A5, 02, 12, 34, 56, 78, 9A, BC, 2E.
  - Required: word_wr pulses with (add 00, 1234), (01, 5678), (02, 9ABC).
  - instr_wenable high from the cycle after A5 until DONE; load_done single pulse; load_error 0.
- Bad checksum: same frame with CHK 2F.
  - Required: three writes occur, then ERR; load_error 1; instr_wenable stays 1; no load_done.
- Recovery from ERR: after the previous case, send A5, 00, AB, CD, 66.
  - Required: load_error clears on A5; write (00, ABCD); load_done pulse; instr_wenable 0.
- Timeout: TIMEOUT = 10; send A5, 00, 11, then no bytes for 10 cycles.
  - Required: ERR; load_error 1; no word_wr.
- Garbage in IDLE and backpressure: send 00, FF, 5A before the nominal frame, with rx_valid toggling every other cycle.
  - Required: junk ignored; instr_wenable stays 0 until A5; writes identical to the nominal case.
- Reset mid-frame: assert reset after A5, 01, 12, 34, 56.
  - Required: next cycle all outputs at reset values; a subsequent full frame loads correctly.

Source files
------------

// File: rtl/prog_loader.sv
// Framed byte-stream bootloader for the 256x16 instruction memory.
// Words are assembled high byte first and written to consecutive addresses; the CPU stays in load mode until the checksum passes.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] inst_data,
  output logic [7:0]  inst_add,
  output logic        instr_wenable,
  output logic        word_wr,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  add_q, add_d;
  logic        wr_q, wr_d;

  logic        acc;
  logic        in_frame;
  logic [15:0] tmo_inc;
  logic        tmo_hit;

  assign rx_ready      = (state_q != DONE);
  assign instr_wenable = (state_q inside {COUNT, HI, LO, CHECK, ERR});
  assign load_done     = (state_q == DONE);
  assign load_error    = (state_q == ERR);
  assign inst_data     = data_q;
  assign inst_add      = add_q;
  assign word_wr       = wr_q;

  assign acc      = rx_valid && rx_ready;
  assign in_frame = (state_q inside {COUNT, HI, LO, CHECK});
  assign tmo_inc  = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
  // A zero TIMEOUT never fires, so an idle sender can hold the frame open indefinitely.
  assign tmo_hit  = (TIMEOUT != 0) && ({16'd0, tmo_inc} >= 32'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    add_d   = add_q;
    wr_d    = 1'b0;

    if (in_frame) tmo_d = acc ? 16'd0 : tmo_inc;

    case (state_q)
      IDLE, ERR: begin
        if (acc && rx_data == SYNC_BYTE) begin
          state_d = COUNT;
          idx_d   = 8'd0;
          chk_d   = 8'd0;
          tmo_d   = 16'd0;
        end
      end
      COUNT: begin
        if (acc) begin
          cnt_d   = rx_data;
          state_d = HI;
        end
      end
      HI: begin
        if (acc) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = LO;
        end
      end
      LO: begin
        if (acc) begin
          chk_d  = chk_q ^ rx_data;
          data_d = {hi_q, rx_data};
          add_d  = idx_q;
          wr_d   = 1'b1;
          if (idx_q == cnt_q) begin
            state_d = CHECK;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = HI;
          end
        end
      end
      CHECK: begin
        if (acc) state_d = (rx_data == chk_q) ? DONE : ERR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (in_frame && !acc && tmo_hit) begin
      state_d = ERR;
      tmo_d   = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      hi_q    <= 8'd0;
      idx_q   <= 8'd0;
      chk_q   <= 8'd0;
      tmo_q   <= 16'd0;
      data_q  <= 16'd0;
      add_q   <= 8'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      add_q   <= add_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table for nominal/bad/recovery frames,
// then hand sequences for backpressure, timeout and mid-frame reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] inst_data;
  logic [7:0]  inst_add;
  logic        instr_wenable;
  logic        word_wr;
  logic        load_done;
  logic        load_error;

  prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .inst_data(inst_data), .inst_add(inst_add), .instr_wenable(instr_wenable),
    .word_wr(word_wr), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [28:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] wq[$];
  int          done_cnt;
  int          errors = 0;
  int          checks = 0;

  bytes_t junk = '{8'h00, 8'hFF, 8'h5A};
  bytes_t nom  = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E};

  always @(negedge clk) begin
    if (word_wr)   wq.push_back({inst_add, inst_data});
    if (load_done) done_cnt++;
  end

  function automatic logic [28:0] outs();
    return {instr_wenable, word_wr, inst_add, inst_data, load_done, load_error, rx_ready};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic addrow(input logic v, input logic [7:0] d, input logic wen, input logic wr,
                        input logic [7:0] add, input logic [15:0] dat, input logic done,
                        input logic err, input logic rdy);
    vec_t r;
    r.v = v; r.d = d;
    r.exp = {wen, wr, add, dat, done, err, rdy};
    vecs.push_back(r);
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Presents one byte, waits (bounded) for acceptance, then idles gap cycles with a SYNC bait on rx_data.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b1; rx_data = b;
    while (!rx_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 10) begin
      errors++; checks++;
      $display("FAIL rx_ready_wait: got 0 want 1");
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'hA5;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_seq(input bytes_t s, input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic chk_nominal_writes(input string tag);
    chk({tag, "_nwr"}, wq.size(), 3);
    if (wq.size() == 3) begin
      chk({tag, "_w0"}, wq[0], 24'h00_1234);
      chk({tag, "_w1"}, wq[1], 24'h01_5678);
      chk({tag, "_w2"}, wq[2], 24'h02_9ABC);
    end
    chk({tag, "_done"}, done_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    done_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", outs(), {1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;

    // Nominal 3-word frame, one byte per cycle
    addrow(1, 8'hA5, 1, 0, 8'h00, 16'h0000, 0, 0, 1);
    addrow(1, 8'h02, 1, 0, 8'h00, 16'h0000, 0, 0, 1);
    addrow(1, 8'h12, 1, 0, 8'h00, 16'h0000, 0, 0, 1);
    addrow(1, 8'h34, 1, 1, 8'h00, 16'h1234, 0, 0, 1);
    addrow(1, 8'h56, 1, 0, 8'h00, 16'h1234, 0, 0, 1);
    addrow(1, 8'h78, 1, 1, 8'h01, 16'h5678, 0, 0, 1);
    addrow(1, 8'h9A, 1, 0, 8'h01, 16'h5678, 0, 0, 1);
    addrow(1, 8'hBC, 1, 1, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'h2E, 0, 0, 8'h02, 16'h9ABC, 1, 0, 0);
    addrow(0, 8'h00, 0, 0, 8'h02, 16'h9ABC, 0, 0, 1);
    // Same frame with bad checksum 2F
    addrow(1, 8'hA5, 1, 0, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'h02, 1, 0, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'h12, 1, 0, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'h34, 1, 1, 8'h00, 16'h1234, 0, 0, 1);
    addrow(1, 8'h56, 1, 0, 8'h00, 16'h1234, 0, 0, 1);
    addrow(1, 8'h78, 1, 1, 8'h01, 16'h5678, 0, 0, 1);
    addrow(1, 8'h9A, 1, 0, 8'h01, 16'h5678, 0, 0, 1);
    addrow(1, 8'hBC, 1, 1, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'h2F, 1, 0, 8'h02, 16'h9ABC, 0, 1, 1);
    addrow(1, 8'h33, 1, 0, 8'h02, 16'h9ABC, 0, 1, 1);
    // Recovery from ERR
    addrow(1, 8'hA5, 1, 0, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'h00, 1, 0, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'hAB, 1, 0, 8'h02, 16'h9ABC, 0, 0, 1);
    addrow(1, 8'hCD, 1, 1, 8'h00, 16'hABCD, 0, 0, 1);
    addrow(1, 8'h66, 0, 0, 8'h00, 16'hABCD, 1, 0, 0);
    addrow(0, 8'h00, 0, 0, 8'h00, 16'hABCD, 0, 0, 1);

    foreach (vecs[i]) begin
      rx_valid = vecs[i].v; rx_data = vecs[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    rx_valid = 1'b0;

    // Junk in IDLE plus backpressure: valid every other cycle, SYNC bait while invalid
    do_reset();
    wq.delete(); done_cnt = 0;
    foreach (junk[i]) begin
      send_byte(junk[i], 1);
      chk($sformatf("junk%0d_wen", i), instr_wenable, 1'b0);
    end
    chk("junk_err", load_error, 1'b0);
    send_seq(nom, 1);
    repeat (2) @(posedge clk); #1;
    chk_nominal_writes("bp");
    chk("bp_wen", instr_wenable, 1'b0);
    chk("bp_err", load_error, 1'b0);

    // Timeout after the high byte: exactly 10 idle cycles aborts
    do_reset();
    wq.delete(); done_cnt = 0;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
    repeat (9) @(posedge clk); #1;
    chk("tmo_early_err", load_error, 1'b0);
    @(posedge clk); #1;
    chk("tmo_err", load_error, 1'b1);
    chk("tmo_wen", instr_wenable, 1'b1);
    chk("tmo_nwr", wq.size(), 0);
    chk("tmo_done", done_cnt, 0);

    // Reset mid-frame, then a clean reload
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
    send_byte(8'h34, 0); send_byte(8'h56, 0);
    chk("mid_wen", instr_wenable, 1'b1);
    do_reset();
    chk("mid_reset_outs", outs(), {1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1});
    wq.delete(); done_cnt = 0;
    send_seq(nom, 0);
    repeat (2) @(posedge clk); #1;
    chk_nominal_writes("reload");
    chk("reload_wen", instr_wenable, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
